// File: rtl/vga_text_pkg.sv
// Shared constants, command encodings and state type for the VGA text controller.
`timescale 1ns/1ps
package vga_text_pkg;

  localparam int         COLS  = 12;
  localparam int         ROWS  = 3;
  localparam int         CELLS = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [1:0] OP_PUT    = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SETCUR = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CLEAR  = 2'b01,
    ST_SCROLL = 2'b10
  } state_e;

  // Characters that PUT stores into the buffer.
  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= 8'h20) && (ch <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_text_buf.sv
// Character cell buffer: one write port, registered display read, combinational scroll read.
`timescale 1ns/1ps
module vga_text_buf #(
  parameter int         CELLS = vga_text_pkg::CELLS,
  parameter logic [7:0] BLANK = vga_text_pkg::BLANK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [5:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [5:0] rd_addr_i,
  output logic [7:0] rd_char_o,
  input  logic [5:0] sc_addr_i,
  output logic [7:0] sc_data_o
);

  logic [7:0] mem_q [CELLS];
  logic [7:0] rd_char_q;

  // Cell storage: reset fills every cell with BLANK, at most one write per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) begin
        mem_q[i] <= BLANK;
      end
    end else if (we_i && (int'(waddr_i) < CELLS)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Display read: samples the pre-write contents, out-of-range addresses read BLANK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_char_q <= BLANK;
    end else if (int'(rd_addr_i) < CELLS) begin
      rd_char_q <= mem_q[rd_addr_i];
    end else begin
      rd_char_q <= BLANK;
    end
  end

  // Scroll read: same-cycle lookup of the source cell one row below.
  always_comb begin
    sc_data_o = BLANK;
    if (int'(sc_addr_i) < CELLS) begin
      sc_data_o = mem_q[sc_addr_i];
    end else begin
      sc_data_o = BLANK;
    end
  end

  assign rd_char_o = rd_char_q;

endmodule

// File: rtl/vga_text_ctrl.sv
// Text-mode VGA controller: host command decode, cursor, clear and scroll sequencing.
`timescale 1ns/1ps
module vga_text_ctrl #(
  parameter int         COLS  = vga_text_pkg::COLS,
  parameter int         ROWS  = vga_text_pkg::ROWS,
  parameter logic [7:0] BLANK = vga_text_pkg::BLANK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [5:0] cur_pos,
  output logic       busy
);

  import vga_text_pkg::*;

  localparam int         NCELLS         = COLS * ROWS;
  localparam logic [5:0] LAST_CELL      = 6'(NCELLS - 1);
  localparam logic [5:0] LAST_ROW_START = 6'((ROWS - 1) * COLS);
  localparam logic [5:0] COLS6          = 6'(COLS);
  localparam logic [5:0] NCELLS6        = 6'(NCELLS);

  state_e     state_q, state_d;
  logic [5:0] cur_q, cur_d;
  logic [5:0] idx_q, idx_d;

  logic       we_s;
  logic [5:0] waddr_s;
  logic [7:0] wdata_s;
  logic [5:0] sc_addr_s;
  logic [7:0] sc_data_s;

  vga_text_buf #(
    .CELLS (NCELLS),
    .BLANK (BLANK)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we_s),
    .waddr_i   (waddr_s),
    .wdata_i   (wdata_s),
    .rd_addr_i (rd_addr),
    .rd_char_o (rd_char),
    .sc_addr_i (sc_addr_s),
    .sc_data_o (sc_data_s)
  );

  // State, cursor and sequence index registers; reset aborts any clear/scroll.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= 6'd0;
      idx_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
    end
  end

  // Next state, cursor update and buffer write selection.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    idx_d     = idx_q;
    we_s      = 1'b0;
    waddr_s   = cur_q;
    wdata_s   = cmd_data;
    sc_addr_s = idx_q + COLS6;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUT: begin
              if (is_printable(cmd_data)) begin
                we_s = 1'b1;
                if (cur_q == LAST_CELL) begin
                  state_d = ST_SCROLL;
                  idx_d   = 6'd0;
                end else begin
                  cur_d = cur_q + 6'd1;
                end
              end else if (cmd_data == CH_LF) begin
                if (cur_q >= LAST_ROW_START) begin
                  state_d = ST_SCROLL;
                  idx_d   = 6'd0;
                end else begin
                  cur_d = (cur_q / COLS6 + 6'd1) * COLS6;
                end
              end else if (cmd_data == CH_BS) begin
                if (cur_q != 6'd0) begin
                  cur_d   = cur_q - 6'd1;
                  we_s    = 1'b1;
                  waddr_s = cur_q - 6'd1;
                  wdata_s = BLANK;
                end else begin
                  cur_d = cur_q;
                end
              end else begin
                cur_d = cur_q;
              end
            end
            OP_CLEAR: begin
              cur_d   = 6'd0;
              idx_d   = 6'd0;
              state_d = ST_CLEAR;
            end
            OP_SETCUR: begin
              if (cmd_data[5:0] < NCELLS6) begin
                cur_d = cmd_data[5:0];
              end else begin
                cur_d = cur_q;
              end
            end
            OP_RSVD: begin
              cur_d = cur_q;
            end
            default: begin
              cur_d = cur_q;
            end
          endcase
        end else begin
          cur_d = cur_q;
        end
      end
      ST_CLEAR: begin
        we_s    = 1'b1;
        waddr_s = idx_q;
        wdata_s = BLANK;
        if (idx_q == LAST_CELL) begin
          state_d = ST_IDLE;
          idx_d   = 6'd0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      ST_SCROLL: begin
        we_s    = 1'b1;
        waddr_s = idx_q;
        if (idx_q < LAST_ROW_START) begin
          wdata_s = sc_data_s;
        end else begin
          wdata_s = BLANK;
        end
        if (idx_q == LAST_CELL) begin
          state_d = ST_IDLE;
          cur_d   = LAST_ROW_START;
          idx_d   = 6'd0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 6'd0;
      end
    endcase
  end

  // Handshake and status outputs decoded straight from the state register.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    cur_pos   = cur_q;
  end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Self-checking bench for vga_text_ctrl against an array-based screen model.
`timescale 1ns/1ps
module tb_vga_text_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [5:0] rd_addr;
  logic [7:0] rd_char;
  logic [5:0] cur_pos;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Screen model: 36 characters and a cursor index.
  logic [7:0] mm [36];
  int         mc;

  vga_text_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rd_addr   (rd_addr),
    .rd_char   (rd_char),
    .cur_pos   (cur_pos),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 36; i++) mm[i] = 8'h20;
    mc = 0;
  endfunction

  // Whole-screen scroll: every row moves up one, bottom row blank, cursor to row 2 col 0.
  function automatic void model_scroll();
    for (int i = 0; i < 24; i++) mm[i] = mm[i + 12];
    for (int i = 24; i < 36; i++) mm[i] = 8'h20;
    mc = 24;
  endfunction

  // Applies one accepted command; returns 1 when the block should go busy for 36 cycles.
  function automatic bit model_cmd(input logic [1:0] op, input logic [7:0] d);
    bit b = 1'b0;
    case (op)
      2'b00: begin
        if (d >= 8'h20 && d <= 8'h7E) begin
          mm[mc] = d;
          if (mc == 35) begin model_scroll(); b = 1'b1; end
          else mc = mc + 1;
        end else if (d == 8'h0A) begin
          if (mc >= 24) begin model_scroll(); b = 1'b1; end
          else mc = (mc / 12 + 1) * 12;
        end else if (d == 8'h08) begin
          if (mc > 0) begin mc = mc - 1; mm[mc] = 8'h20; end
        end
      end
      2'b01: begin
        for (int i = 0; i < 36; i++) mm[i] = 8'h20;
        mc = 0;
        b  = 1'b1;
      end
      2'b10: if (int'(d[5:0]) < 36) mc = int'(d[5:0]);
      default: ;
    endcase
    return b;
  endfunction

  // Issues one command from IDLE, measures the busy window, checks the cursor.
  task automatic send(input logic [1:0] op, input logic [7:0] d, input bit hold);
    int nb;
    int nr;
    bit exp_busy;
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    step();
    exp_busy = model_cmd(op, d);
    if (hold) begin
      cmd_op   = 2'b00;
      cmd_data = 8'h58;
    end else begin
      cmd_valid = 1'b0;
    end
    nb = 0;
    nr = 0;
    while ((busy === 1'b1) && (nb < 100)) begin
      if (cmd_ready === 1'b0) nr++;
      step();
      nb++;
    end
    cmd_valid = 1'b0;
    check($sformatf("busy_cycles op=%0d d=%0h", op, d), 32'(nb), exp_busy ? 32'd36 : 32'd0);
    check("ready_low_cycles", 32'(nr), exp_busy ? 32'd36 : 32'd0);
    check($sformatf("cur_pos op=%0d d=%0h", op, d), 32'(cur_pos), 32'(mc));
  endtask

  task automatic read_cell(input int a, input logic [7:0] exp);
    rd_addr = 6'(a);
    step();
    check($sformatf("rd_char[%0d]", a), 32'(rd_char), 32'(exp));
  endtask

  task automatic check_all();
    for (int i = 0; i < 36; i++) read_cell(i, mm[i]);
    read_cell(40, 8'h20);
    read_cell(63, 8'h20);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    rd_addr   = 6'd0;
    model_reset();
    repeat (2) step();
    check("reset_rd_char", 32'(rd_char), 32'h20);
    check("reset_cur_pos", 32'(cur_pos), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // Two characters at the home position.
    send(2'b00, 8'h41, 1'b0);
    send(2'b00, 8'h42, 1'b0);
    read_cell(0, 8'h41);
    read_cell(1, 8'h42);
    check("cur_after_AB", 32'(cur_pos), 32'd2);

    // Write and read the same cell on one edge: old value first, new value next.
    rd_addr   = 6'd2;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 8'h43;
    step();
    void'(model_cmd(2'b00, 8'h43));
    cmd_valid = 1'b0;
    check("same_edge_old", 32'(rd_char), 32'h20);
    step();
    check("same_edge_new", 32'(rd_char), 32'h43);

    // Printable at the last cell scrolls.
    send(2'b10, 8'd35, 1'b0);
    send(2'b00, 8'h5A, 1'b0);
    check_all();
    check("cell23_Z", 32'(mm[23]), 32'h5A);

    // Line feed inside the screen and on the last row.
    send(2'b10, 8'd5, 1'b0);
    send(2'b00, 8'h0A, 1'b0);
    check("lf_row0", 32'(cur_pos), 32'd12);
    send(2'b10, 8'd30, 1'b0);
    send(2'b00, 8'h0A, 1'b0);
    check("lf_row2", 32'(cur_pos), 32'd24);
    check_all();

    // Fill the screen, then clear with cmd_valid held high throughout.
    send(2'b10, 8'd0, 1'b0);
    for (int i = 0; i < 35; i++) send(2'b00, 8'(8'h61 + 8'(i % 26)), 1'b0);
    check_all();
    send(2'b01, 8'h00, 1'b1);
    check("clear_cur", 32'(cur_pos), 32'd0);
    check_all();

    // Backspace at home and mid-row, plus ignored commands.
    send(2'b00, 8'h08, 1'b0);
    check("bs_home", 32'(cur_pos), 32'd0);
    send(2'b00, 8'h31, 1'b0);
    send(2'b00, 8'h32, 1'b0);
    send(2'b00, 8'h33, 1'b0);
    send(2'b00, 8'h08, 1'b0);
    check("bs_cur", 32'(cur_pos), 32'd2);
    send(2'b10, 8'd40, 1'b0);
    send(2'b11, 8'h07, 1'b0);
    send(2'b00, 8'h01, 1'b0);
    send(2'b00, 8'hC5, 1'b0);
    check_all();

    // Randomized command mix against the model.
    for (int n = 0; n < 150; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r <= 11)      send(2'b00, 8'($urandom_range(32, 126)), 1'b0);
      else if (r == 12) send(2'b00, 8'h0A, 1'b0);
      else if (r == 13) send(2'b00, 8'h08, 1'b0);
      else if (r == 14) send(2'b00, 8'($urandom_range(128, 255)), 1'b0);
      else if (r <= 16) send(2'b10, 8'($urandom_range(0, 63)), 1'b0);
      else if (r == 17) send(2'b11, 8'($urandom_range(0, 255)), 1'b0);
      else if (r == 18) send(2'b01, 8'h00, 1'b0);
      else begin
        int a;
        a = int'($urandom_range(0, 35));
        read_cell(a, mm[a]);
      end
    end
    check_all();

    // Reset in the middle of a scroll.
    send(2'b10, 8'd35, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 8'h5A;
    step();
    cmd_valid = 1'b0;
    check("scroll_cycle0_busy", 32'(busy), 32'd1);
    repeat (10) step();
    check("scroll_cycle10_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_cur", 32'(cur_pos), 32'd0);
    check("abort_rd_char", 32'(rd_char), 32'h20);
    check_all();
    step();
    check("abort_stays_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
